// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-master SDRAM Avalon-MM arbiter: FSM states and
// the master-ID tag stored per outstanding read.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    typedef logic mid_t;

    localparam mid_t MID_M0 = 1'b0;
    localparam mid_t MID_M1 = 1'b1;

endpackage

// File: rtl/sdram_avmm_arbiter_if.sv
// One Avalon-MM pipelined-read port; "master" drives commands, "slave" answers.
interface sdram_avmm_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16,
    parameter int BE_W   = 2
) ();

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/arb_id_fifo.sv
// Show-ahead FIFO of master IDs, one entry per read still awaiting its data.
module arb_id_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sdram_avmm_arbiter.sv
// Round-robin arbiter letting two Avalon-MM masters share one SDRAM slave,
// with read responses steered back to their issuer through an ID FIFO.
module sdram_avmm_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int BE_W    = 2,
    parameter int OUT_MAX = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    sdram_avmm_arbiter_if.slave      m0,
    sdram_avmm_arbiter_if.slave      m1,
    sdram_avmm_arbiter_if.master     s,
    output logic [$clog2(OUT_MAX):0] rd_outstanding,
    output logic                     err_unexp_rdv
);

    state_t state_q, state_d;
    mid_t   last_q, last_d;
    logic   err_q, err_d;

    logic              req0, req1, own_req, other_req;
    logic              wr_c, mrd_c, rd_c, rd_block, accept;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;
    logic [BE_W-1:0]   be_c;
    mid_t              sel, head;
    state_t            other_state;
    logic              fifo_full, fifo_empty, push, pop;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    always_comb begin
        sel         = (state_q == OWN1) ? MID_M1 : MID_M0;
        other_state = (state_q == OWN1) ? OWN0 : OWN1;
        other_req   = (state_q == OWN1) ? req0 : req1;
        addr_c      = '0;
        wdata_c     = '0;
        be_c        = '0;
        wr_c        = 1'b0;
        mrd_c       = 1'b0;
        own_req     = 1'b0;
        if (state_q == OWN0) begin
            addr_c  = m0.address;
            wdata_c = m0.writedata;
            be_c    = m0.byteenable;
            wr_c    = m0.write;
            mrd_c   = m0.read & ~m0.write;
            own_req = req0;
        end else if (state_q == OWN1) begin
            addr_c  = m1.address;
            wdata_c = m1.writedata;
            be_c    = m1.byteenable;
            wr_c    = m1.write;
            mrd_c   = m1.read & ~m1.write;
            own_req = req1;
        end
        // A read with no free ID slot is held off; writes never need one.
        rd_block = fifo_full & mrd_c;
        rd_c     = mrd_c & ~fifo_full;
        accept   = (rd_c | wr_c) & ~s.waitrequest;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) state_d = (last_q == MID_M0) ? OWN1 : OWN0;
                else if (req0)    state_d = OWN0;
                else if (req1)    state_d = OWN1;
            end
            default: begin
                if (accept) begin
                    last_d = sel;
                    if (other_req)    state_d = other_state;
                    else if (own_req) state_d = state_q;
                    else              state_d = IDLE;
                end else if (!own_req) begin
                    state_d = other_req ? other_state : IDLE;
                end
            end
        endcase
    end

    assign push  = accept & rd_c;
    assign pop   = s.readdatavalid;
    assign err_d = err_q | (s.readdatavalid & fifo_empty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= MID_M1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    arb_id_fifo #(
        .DEPTH(OUT_MAX),
        .W    (1)
    ) u_id_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .din    (sel),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (rd_outstanding)
    );

    assign s.address    = addr_c;
    assign s.writedata  = wdata_c;
    assign s.byteenable = be_c;
    assign s.write      = wr_c;
    assign s.read       = rd_c;

    assign m0.waitrequest   = (state_q == OWN0) ? (s.waitrequest | rd_block) : 1'b1;
    assign m1.waitrequest   = (state_q == OWN1) ? (s.waitrequest | rd_block) : 1'b1;
    assign m0.readdata      = s.readdata;
    assign m1.readdata      = s.readdata;
    assign m0.readdatavalid = s.readdatavalid & ~fifo_empty & (head == MID_M0);
    assign m1.readdatavalid = s.readdatavalid & ~fifo_empty & (head == MID_M1);
    assign err_unexp_rdv    = err_q;

endmodule

// File: tb/tb_sdram_avmm_arbiter.sv
// Directed bench: dut_a (8 outstanding reads) covers grant, hold, routing and
// reset; dut_b (2 outstanding reads) covers the full-FIFO read stall.
module tb_sdram_avmm_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    int   total  = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    sdram_avmm_arbiter_if #(.ADDR_W(25), .DATA_W(16), .BE_W(2)) a_m0 ();
    sdram_avmm_arbiter_if #(.ADDR_W(25), .DATA_W(16), .BE_W(2)) a_m1 ();
    sdram_avmm_arbiter_if #(.ADDR_W(25), .DATA_W(16), .BE_W(2)) a_s ();
    sdram_avmm_arbiter_if #(.ADDR_W(25), .DATA_W(16), .BE_W(2)) b_m0 ();
    sdram_avmm_arbiter_if #(.ADDR_W(25), .DATA_W(16), .BE_W(2)) b_m1 ();
    sdram_avmm_arbiter_if #(.ADDR_W(25), .DATA_W(16), .BE_W(2)) b_s ();

    logic [3:0] a_rd_out;
    logic       a_err;
    logic [1:0] b_rd_out;
    logic       b_err;

    sdram_avmm_arbiter #(.ADDR_W(25), .DATA_W(16), .BE_W(2), .OUT_MAX(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .m0(a_m0), .m1(a_m1), .s(a_s),
        .rd_outstanding(a_rd_out), .err_unexp_rdv(a_err)
    );

    sdram_avmm_arbiter #(.ADDR_W(25), .DATA_W(16), .BE_W(2), .OUT_MAX(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .m0(b_m0), .m1(b_m1), .s(b_s),
        .rd_outstanding(b_rd_out), .err_unexp_rdv(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        a_m0.address = '0; a_m0.read = 0; a_m0.write = 0; a_m0.writedata = '0; a_m0.byteenable = '0;
        a_m1.address = '0; a_m1.read = 0; a_m1.write = 0; a_m1.writedata = '0; a_m1.byteenable = '0;
        b_m0.address = '0; b_m0.read = 0; b_m0.write = 0; b_m0.writedata = '0; b_m0.byteenable = '0;
        b_m1.address = '0; b_m1.read = 0; b_m1.write = 0; b_m1.writedata = '0; b_m1.byteenable = '0;
        a_s.waitrequest = 0; a_s.readdata = '0; a_s.readdatavalid = 0;
        b_s.waitrequest = 0; b_s.readdata = '0; b_s.readdatavalid = 0;
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_m0_wait", a_m0.waitrequest, 1);
        chk("rst_m1_wait", a_m1.waitrequest, 1);
        chk("rst_s_read", a_s.read, 0);
        chk("rst_s_write", a_s.write, 0);
        chk("rst_rd_out", a_rd_out, 0);
        chk("rst_err", a_err, 0);
        chk("rst_m0_rdv", a_m0.readdatavalid, 0);
        @(negedge clk); reset_n = 1'b1;

        // Single write from m0
        @(negedge clk);
        a_m0.write = 1; a_m0.address = 25'h0000100; a_m0.writedata = 16'hBEEF; a_m0.byteenable = 2'b11;
        #1;
        chk("wr1_idle_s_write", a_s.write, 0);
        chk("wr1_idle_m0_wait", a_m0.waitrequest, 1);
        @(negedge clk); #1;
        chk("wr1_s_write", a_s.write, 1);
        chk("wr1_s_addr", a_s.address, 32'h100);
        chk("wr1_s_wdata", a_s.writedata, 32'hBEEF);
        chk("wr1_s_be", a_s.byteenable, 3);
        chk("wr1_m0_wait", a_m0.waitrequest, 0);
        chk("wr1_m1_wait", a_m1.waitrequest, 1);
        @(negedge clk); a_m0.write = 0; #1;
        chk("wr1_done_s_write", a_s.write, 0);
        // m0 won last, so a tie now goes to m1
        @(negedge clk);
        a_m0.write = 1; a_m0.address = 25'h10; a_m1.write = 1; a_m1.address = 25'h20;
        #1;
        chk("tie_idle_m1_wait", a_m1.waitrequest, 1);
        @(negedge clk); #1;
        chk("tie_last_addr", a_s.address, 32'h20);
        chk("tie_last_m1_wait", a_m1.waitrequest, 0);
        chk("tie_last_m0_wait", a_m0.waitrequest, 1);
        @(negedge clk); a_m0.write = 0; a_m1.write = 0; #1;
        chk("tie_drop_s_write", a_s.write, 0);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;

        // Simultaneous writes after reset alternate m0, m1, m0, m1
        @(negedge clk);
        a_m0.write = 1; a_m0.address = 25'hA0; a_m0.writedata = 16'h0A0A;
        a_m1.write = 1; a_m1.address = 25'hB0; a_m1.writedata = 16'h0B0B;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("rr_s_write", a_s.write, 1);
            chk("rr_s_addr", a_s.address, (i % 2 == 0) ? 32'hA0 : 32'hB0);
            chk("rr_m0_wait", a_m0.waitrequest, (i % 2 == 0) ? 0 : 1);
            chk("rr_m1_wait", a_m1.waitrequest, (i % 2 == 0) ? 1 : 0);
        end
        @(negedge clk); a_m0.write = 0; a_m1.write = 0; #1;
        chk("rr_end_s_write", a_s.write, 0);

        // Interleaved reads: m0 A, m1 B, m0 C, each answered 3 cycles later
        @(negedge clk); a_m0.read = 1; a_m0.address = 25'hA;
        @(negedge clk); a_m1.read = 1; a_m1.address = 25'hB; #1;
        chk("rd_a_s_read", a_s.read, 1);
        chk("rd_a_addr", a_s.address, 32'hA);
        chk("rd_a_m1_wait", a_m1.waitrequest, 1);
        @(negedge clk); a_m0.address = 25'hC; #1;
        chk("rd_b_addr", a_s.address, 32'hB);
        chk("rd_b_m1_wait", a_m1.waitrequest, 0);
        chk("rd_b_out", a_rd_out, 1);
        @(negedge clk); a_m1.read = 0; #1;
        chk("rd_c_addr", a_s.address, 32'hC);
        chk("rd_c_s_read", a_s.read, 1);
        chk("rd_c_out", a_rd_out, 2);
        @(negedge clk); a_m0.read = 0; a_s.readdatavalid = 1; a_s.readdata = 16'h1111; #1;
        chk("rd_peak_out", a_rd_out, 3);
        chk("rsp1_m0_rdv", a_m0.readdatavalid, 1);
        chk("rsp1_m1_rdv", a_m1.readdatavalid, 0);
        chk("rsp1_m0_data", a_m0.readdata, 32'h1111);
        chk("rsp1_m1_data", a_m1.readdata, 32'h1111);
        @(negedge clk); a_s.readdata = 16'h2222; #1;
        chk("rsp2_m0_rdv", a_m0.readdatavalid, 0);
        chk("rsp2_m1_rdv", a_m1.readdatavalid, 1);
        chk("rsp2_out", a_rd_out, 2);
        @(negedge clk); a_s.readdata = 16'h3333; #1;
        chk("rsp3_m0_rdv", a_m0.readdatavalid, 1);
        chk("rsp3_m1_rdv", a_m1.readdatavalid, 0);
        chk("rsp3_out", a_rd_out, 1);
        @(negedge clk); a_s.readdatavalid = 0; #1;
        chk("rsp_done_out", a_rd_out, 0);
        chk("rsp_done_m0_rdv", a_m0.readdatavalid, 0);
        chk("rsp_done_err", a_err, 0);

        // Waitrequest hold: m0 keeps the slave while stalled even though m1 asks
        @(negedge clk); a_m0.write = 1; a_m0.address = 25'h55; a_s.waitrequest = 1;
        @(negedge clk); a_m1.write = 1; a_m1.address = 25'h66; #1;
        chk("hold_addr", a_s.address, 32'h55);
        chk("hold_m0_wait", a_m0.waitrequest, 1);
        chk("hold_m1_wait", a_m1.waitrequest, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("hold_addr_loop", a_s.address, 32'h55);
        end
        @(negedge clk); a_s.waitrequest = 0; #1;
        chk("hold_release_addr", a_s.address, 32'h55);
        chk("hold_release_m0_wait", a_m0.waitrequest, 0);
        @(negedge clk); a_m0.write = 0; #1;
        chk("hold_next_addr", a_s.address, 32'h66);
        chk("hold_next_m1_wait", a_m1.waitrequest, 0);
        @(negedge clk); a_m1.write = 0; #1;
        chk("hold_end_s_write", a_s.write, 0);

        // Reset with two reads in flight, then a stray response
        @(negedge clk); a_m0.read = 1; a_m0.address = 25'h7;
        @(negedge clk); #1;
        chk("mid_s_read", a_s.read, 1);
        @(negedge clk); a_m0.address = 25'h8; #1;
        chk("mid_out1", a_rd_out, 1);
        @(negedge clk); a_m0.read = 0; #1;
        chk("mid_out2", a_rd_out, 2);
        @(negedge clk); reset_n = 1'b0; #1;
        chk("mid_rst_out", a_rd_out, 0);
        chk("mid_rst_m0_wait", a_m0.waitrequest, 1);
        chk("mid_rst_m1_wait", a_m1.waitrequest, 1);
        chk("mid_rst_err", a_err, 0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); a_s.readdatavalid = 1; a_s.readdata = 16'h4444; #1;
        chk("stray_m0_rdv", a_m0.readdatavalid, 0);
        chk("stray_m1_rdv", a_m1.readdatavalid, 0);
        @(negedge clk); a_s.readdatavalid = 0; #1;
        chk("stray_err", a_err, 1);
        chk("stray_out", a_rd_out, 0);
        @(negedge clk); #1;
        chk("stray_err_sticky", a_err, 1);

        // Full ID FIFO on dut_b: m1 read stalls, m1 write passes
        @(negedge clk); b_m0.read = 1; b_m0.address = 25'h1;
        @(negedge clk); #1;
        chk("full_r1_s_read", b_s.read, 1);
        @(negedge clk); b_m0.address = 25'h2; #1;
        chk("full_out1", b_rd_out, 1);
        @(negedge clk); b_m0.read = 0; b_m1.read = 1; b_m1.address = 25'h3; #1;
        chk("full_out2", b_rd_out, 2);
        chk("full_handover_s_read", b_s.read, 0);
        @(negedge clk); #1;
        chk("full_block_s_read", b_s.read, 0);
        chk("full_block_m1_wait", b_m1.waitrequest, 1);
        @(negedge clk); b_m1.read = 0; b_m1.write = 1; b_m1.address = 25'h9; #1;
        chk("full_wr_s_write", b_s.write, 1);
        chk("full_wr_m1_wait", b_m1.waitrequest, 0);
        @(negedge clk);
        b_m1.write = 0; b_m1.read = 1; b_m1.address = 25'h3;
        b_s.readdatavalid = 1; b_s.readdata = 16'h5555; #1;
        chk("full_still_s_read", b_s.read, 0);
        chk("full_still_m1_wait", b_m1.waitrequest, 1);
        chk("full_pop_m0_rdv", b_m0.readdatavalid, 1);
        chk("full_pop_m1_rdv", b_m1.readdatavalid, 0);
        @(negedge clk); b_s.readdatavalid = 0; #1;
        chk("full_issue_s_read", b_s.read, 1);
        chk("full_issue_addr", b_s.address, 32'h3);
        chk("full_issue_m1_wait", b_m1.waitrequest, 0);
        chk("full_issue_out", b_rd_out, 1);
        @(negedge clk); b_m1.read = 0; #1;
        chk("full_final_out", b_rd_out, 2);
        chk("full_final_err", b_err, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/sdram_avmm_arbiter.md
Name: sdram_avmm_arbiter

Overview:
- Two-master to one-slave Avalon-MM arbiter.
- Lets the Nios II data path (m0) and a fabric DMA/frame reader (m1) share the single SDRAM controller slave port in the SoC.
- Round-robin grant, pipelined reads, and routing of each read response back to the master that issued it.
- Sits in FPGA fabric between the two masters and the SDRAM controller's Avalon slave.

Parameters:
ADDR_W, 25, word address width (32M x16 SDRAM)
DATA_W, 16, data width
BE_W, 2, byteenable width (DATA_W/8)
OUT_MAX, 8, max outstanding reads; depth of the ID FIFO (power of 2, >=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  master 0 address
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_byteenable  in  BE_W  master 0 byte enables
m0_waitrequest  out  1  master 0 stall
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  master 0 read data valid
m1_*  same eight signals as m0_*, for master 1
s_address  out  ADDR_W  to SDRAM controller
s_read  out  1  slave read
s_write  out  1  slave write
s_writedata  out  DATA_W  slave write data
s_byteenable  out  BE_W  slave byte enables
s_waitrequest  in  1  slave stall
s_readdata  in  DATA_W  slave read data
s_readdatavalid  in  1  slave read data valid
rd_outstanding  out  $clog2(OUT_MAX)+1  reads issued but not yet returned
err_unexp_rdv  out  1  sticky: readdatavalid arrived with no read outstanding

Behaviour:
- Reset (async assert, sync release): state=IDLE, last=1 (so m0 wins the first tie), ID FIFO empty, rd_outstanding=0, err_unexp_rdv=0. Both m*_waitrequest=1; s_read=s_write=0; both m*_readdatavalid=0.
- Request: reqX = mX_read | mX_write. Read with write asserted together is illegal; write takes precedence.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: no slave command is driven and both waitrequests=1.
  - IDLE with any reqX: move to OWNx next cycle. If both request, pick the master != last. One cycle of arbitration latency.
  - OWNx: s_address, s_writedata, s_byteenable, s_write and s_read are taken combinationally from master x. mX_waitrequest = s_waitrequest | rd_block. The other master's waitrequest=1.
  - rd_block = FIFO full & mX_read. While rd_block is high, s_read is forced to 0 (the read stalls); writes still pass.
  - Accept = (s_read|s_write) & ~s_waitrequest. On accept: last<=x. Next state is OWN(other) if the other master requests, else OWNx if x requests, else IDLE. Back-to-back transfers need no idle cycle.
  - While s_waitrequest=1 the grant never changes (Avalon hold rule).
  - OWNx with reqX dropped and no accept: go to OWN(other) if it requests, else IDLE.
- Read routing:
  - An accepted read pushes x into the ID FIFO.
  - s_readdatavalid pops the FIFO head h and asserts mH_readdatavalid in the same cycle (combinational).
  - s_readdata is broadcast to both m*_readdata.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - FIFO wrap-around uses ADDR pointers mod OUT_MAX.
- rd_outstanding equals the FIFO count and is registered.
- s_readdatavalid with an empty FIFO: no m*_readdatavalid, no pop, err_unexp_rdv<=1. It stays set until reset.
- Reset mid-operation: all outstanding reads are dropped. Responses arriving after reset count as unexpected.

Decomposition:
- Package sdram_arb_pkg holds: the state_t enum {IDLE, OWN0, OWN1}, the mid_t master-ID typedef (1 bit), and the MID_M0/MID_M1 constants.
- One sub-module, arb_id_fifo: parameters DEPTH and W. Ports push, pop, din, dout, full, empty, count. Show-ahead output. Async active-low reset, same clk/reset_n.

Test Plan:
- Single write: m0_write, addr 0x0000100, data 0xBEEF, be 2'b11, s_waitrequest=0. Result: s_write high in cycle 2 (after IDLE->OWN0), m0_waitrequest low in that cycle, last=0.
- Simultaneous requests after reset: m0 and m1 both write. Result: order m0, m1, m0, m1 on the slave with no idle cycles between; each non-granted waitrequest stays 1.
- Interleaved reads: 3-cycle-latency slave model; m0 reads A, m1 reads B, m0 reads C. Result: responses 0x1111/0x2222/0x3333 assert m0/m1/m0_readdatavalid in that order; rd_outstanding peaks at 3 and returns to 0.
- FIFO full, OUT_MAX=2: two reads outstanding, a third read from m1 is stalled (s_read=0, m1_waitrequest=1). A write from m1 still passes. After one readdatavalid, the stalled read is issued the next cycle.
- Waitrequest hold: s_waitrequest=1 for 5 cycles while m0 owns and m1 requests. Result: s_address stays m0's; grant moves to m1 only after accept.
- Reset mid-read plus a stray response: assert reset_n=0 with 2 reads outstanding. Result: rd_outstanding=0 and both waitrequests=1. A later s_readdatavalid sets err_unexp_rdv=1 and drives no m*_readdatavalid.
